// File: rtl/layer_stream_serializer_pkg.sv
// Shared types and helpers for the layer output stream serializer.
// Holds the default word width, the index width helper and the FSM states.
package layer_stream_serializer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // A single-word vector still needs a one-bit index port.
  function automatic int calc_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_vec_fifo.sv
// Purpose: two-entry FIFO holding whole layer output vectors.
// Latency: a push is visible at head_dat/next_dat after one clock edge.
// Backpressure: none internally; the caller pushes only when not full or when popping in the same cycle.
module layer_vec_fifo
  import layer_stream_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_aresetn,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [WIDTH-1:0] next_dat,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] slot_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (clear) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      if (push && !pop)      count_q <= count_q + 2'd1;
      else if (pop && !push) count_q <= count_q - 2'd1;
    end
  end

  // Vector storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge s_axi_aclk) begin
    if (push && !clear) slot_q[wr_ptr_q] <= push_dat;
  end

  assign head_dat = slot_q[rd_ptr_q];
  assign next_dat = slot_q[~rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == 2'd2);
  assign empty    = (count_q == 2'd0);

endmodule

// File: rtl/layer_stream_serializer.sv
// Purpose: buffers up to two layer output vectors and streams them word by word, neuron 0 first.
// Latency: a vector captured at edge N presents neuron 0 after edge N+1; back-to-back vectors have no bubble.
// Backpressure: out_ready stalls the stream with outputs held; a vector arriving with both slots full is dropped and flagged.
module layer_stream_serializer
  import layer_stream_serializer_pkg::*;
#(
  parameter  int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter  int NUM_NEURONS = 30,
  localparam int IDX_WIDTH   = calc_idx_width(NUM_NEURONS)
) (
  input  logic                              s_axi_aclk,
  input  logic                              s_axi_aresetn,
  input  logic                              soft_reset,
  input  logic [NUM_NEURONS-1:0]            in_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  output logic                              in_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic [IDX_WIDTH-1:0]              out_index,
  output logic                              busy,
  output logic                              overflow
);

  localparam int                   VEC_WIDTH = NUM_NEURONS * DATA_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_NEURONS - 1);
  localparam logic                 ONE_WORD  = (NUM_NEURONS == 1);

  ser_state_t            state_q;
  ser_state_t            state_d;
  logic                  valid_d;
  logic                  last_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [IDX_WIDTH-1:0]  index_d;
  logic [IDX_WIDTH-1:0]  index_inc;

  logic [VEC_WIDTH-1:0]  head_dat;
  logic [VEC_WIDTH-1:0]  next_dat;
  logic [VEC_WIDTH-1:0]  follow_dat;
  logic [1:0]            fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic                  beat;
  logic                  pop;
  logic                  push;
  logic                  more_after_pop;
  logic                  unused_in_valid;

  function automatic logic [DATA_WIDTH-1:0] word_at(input logic [VEC_WIDTH-1:0] vec,
                                                    input logic [IDX_WIDTH-1:0] idx);
    return vec[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // Only neuron 0's valid qualifies the whole vector.
  assign unused_in_valid = ^in_valid;

  assign beat      = out_valid & out_ready;
  assign pop       = beat & out_last;
  assign push      = in_valid[0] & (~fifo_full | pop);
  assign in_ready  = ~fifo_full;
  assign busy      = ~fifo_empty | out_valid;
  assign index_inc = out_index + IDX_WIDTH'(1);

  // After popping the head, the next vector is either the second slot or the one arriving now.
  assign more_after_pop = fifo_count[1] | push;
  assign follow_dat     = fifo_count[1] ? next_dat : in_data;

  layer_vec_fifo #(
    .WIDTH(VEC_WIDTH)
  ) u_vec_fifo (
    .s_axi_aclk   (s_axi_aclk),
    .s_axi_aresetn(s_axi_aresetn),
    .clear        (soft_reset),
    .push         (push),
    .push_dat     (in_data),
    .pop          (pop),
    .head_dat     (head_dat),
    .next_dat     (next_dat),
    .count        (fifo_count),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
    end else if (soft_reset) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= valid_d;
      out_last  <= last_d;
      out_index <= index_d;
      out_data  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = SEND;
      SEND:    if (pop && !more_after_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered output values for the next cycle; holding is the default so a stall changes nothing.
  always_comb begin
    valid_d = out_valid;
    last_d  = out_last;
    index_d = out_index;
    data_d  = out_data;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          valid_d = 1'b1;
          index_d = '0;
          data_d  = word_at(head_dat, '0);
          last_d  = ONE_WORD;
        end
      end
      SEND: begin
        if (beat) begin
          if (!out_last) begin
            index_d = index_inc;
            data_d  = word_at(head_dat, index_inc);
            last_d  = (index_inc == LAST_IDX);
          end else if (more_after_pop) begin
            index_d = '0;
            data_d  = word_at(follow_dat, '0);
            last_d  = ONE_WORD;
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            index_d = '0;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      overflow <= 1'b0;
    end else if (soft_reset) begin
      overflow <= 1'b0;
    end else if (in_valid[0] && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_layer_stream_serializer.sv
// Directed bench for layer_stream_serializer: a 4-word instance and a 1-word instance
// share clock and resets; expected beats are queued at capture and checked on handshake.
module tb_layer_stream_serializer;

  localparam int DW = 16;
  localparam int NA = 4;
  localparam int NB = 1;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic [1:0]    idx;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic soft_reset;

  logic [NA-1:0]    a_in_valid;
  logic [NA*DW-1:0] a_in_data;
  logic             a_in_ready;
  logic [DW-1:0]    a_out_data;
  logic             a_out_valid;
  logic             a_out_ready;
  logic             a_out_last;
  logic [1:0]       a_out_index;
  logic             a_busy;
  logic             a_overflow;

  logic [NB-1:0]    b_in_valid;
  logic [NB*DW-1:0] b_in_data;
  logic             b_in_ready;
  logic [DW-1:0]    b_out_data;
  logic             b_out_valid;
  logic             b_out_ready;
  logic             b_out_last;
  logic [0:0]       b_out_index;
  logic             b_busy;
  logic             b_overflow;

  int   n_checks = 0;
  int   n_errors = 0;
  int   a_beats  = 0;
  int   b_beats  = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  layer_stream_serializer #(.DATA_WIDTH(DW), .NUM_NEURONS(NA)) u_dut_a (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .soft_reset(soft_reset),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_last(a_out_last), .out_index(a_out_index), .busy(a_busy), .overflow(a_overflow)
  );

  layer_stream_serializer #(.DATA_WIDTH(DW), .NUM_NEURONS(NB)) u_dut_b (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .soft_reset(soft_reset),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_last(b_out_last), .out_index(b_out_index), .busy(b_busy), .overflow(b_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap_a(input logic [DW-1:0] base, input bit accept);
    exp_t e;
    for (int k = 0; k < NA; k++) begin
      a_in_data[k*DW +: DW] = base + DW'(k);
      e.dat  = base + DW'(k);
      e.idx  = 2'(k);
      e.last = (k == NA - 1);
      if (accept) sb_a.push_back(e);
    end
    a_in_valid = {3'($urandom), 1'b1};
    tick();
    a_in_valid = '0;
  endtask

  task automatic cap_b(input logic [DW-1:0] word, input bit accept);
    exp_t e;
    e.dat  = word;
    e.idx  = 2'd0;
    e.last = 1'b1;
    if (accept) sb_b.push_back(e);
    b_in_data  = word;
    b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit on_b, input string tag, input int limit);
    int n = 0;
    while ((on_b ? b_busy : a_busy) && n < limit) begin
      tick();
      n++;
    end
    chk(tag, 32'(on_b ? b_busy : a_busy), 32'd0);
  endtask

  // Scoreboard and stall-stability monitor for the 4-word instance.
  bit            a_stalled = 1'b0;
  logic [DW-1:0] a_hold_dat;
  logic [1:0]    a_hold_idx;
  logic          a_hold_last;
  exp_t          ea;
  always @(negedge clk) begin
    if (!rst_n || soft_reset) begin
      a_stalled = 1'b0;
    end else begin
      if (a_stalled) begin
        chk("a_hold_valid", 32'(a_out_valid), 32'd1);
        chk("a_hold_data",  32'(a_out_data),  32'(a_hold_dat));
        chk("a_hold_index", 32'(a_out_index), 32'(a_hold_idx));
        chk("a_hold_last",  32'(a_out_last),  32'(a_hold_last));
      end
      if (a_out_valid && a_out_ready) begin
        a_beats++;
        chk("a_beat_expected", 32'(sb_a.size() != 0), 32'd1);
        if (sb_a.size() != 0) begin
          ea = sb_a.pop_front();
          chk("a_beat_data",  32'(a_out_data),  32'(ea.dat));
          chk("a_beat_index", 32'(a_out_index), 32'(ea.idx));
          chk("a_beat_last",  32'(a_out_last),  32'(ea.last));
        end
      end
      a_stalled   = a_out_valid && !a_out_ready;
      a_hold_dat  = a_out_data;
      a_hold_idx  = a_out_index;
      a_hold_last = a_out_last;
    end
  end

  exp_t eb;
  always @(negedge clk) begin
    if (rst_n && !soft_reset && b_out_valid && b_out_ready) begin
      b_beats++;
      chk("b_beat_expected", 32'(sb_b.size() != 0), 32'd1);
      if (sb_b.size() != 0) begin
        eb = sb_b.pop_front();
        chk("b_beat_data",  32'(b_out_data),  32'(eb.dat));
        chk("b_beat_index", 32'(b_out_index), 32'(eb.idx));
        chk("b_beat_last",  32'(b_out_last),  32'(eb.last));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, n_errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int beats0;
    int pattern [7] = '{1, 0, 0, 1, 0, 1, 1};

    rst_n       = 1'b0;
    soft_reset  = 1'b0;
    a_in_valid  = '0;
    a_in_data   = '0;
    a_out_ready = 1'b1;
    b_in_valid  = '0;
    b_in_data   = '0;
    b_out_ready = 1'b1;

    // Reset values
    #1;
    chk("rst_a_valid",    32'(a_out_valid), 32'd0);
    chk("rst_a_last",     32'(a_out_last),  32'd0);
    chk("rst_a_index",    32'(a_out_index), 32'd0);
    chk("rst_a_data",     32'(a_out_data),  32'd0);
    chk("rst_a_busy",     32'(a_busy),      32'd0);
    chk("rst_a_overflow", 32'(a_overflow),  32'd0);
    chk("rst_a_in_ready", 32'(a_in_ready),  32'd1);
    chk("rst_b_valid",    32'(b_out_valid), 32'd0);
    chk("rst_b_in_ready", 32'(b_in_ready),  32'd1);
    #20;
    rst_n = 1'b1;
    tick();

    // Basic order with out_ready high
    beats0 = a_beats;
    cap_a(16'h0001, 1'b1);
    chk("basic_no_valid_yet", 32'(a_out_valid), 32'd0);
    chk("basic_busy",         32'(a_busy),      32'd1);
    tick();
    chk("basic_first_valid",  32'(a_out_valid), 32'd1);
    chk("basic_first_data",   32'(a_out_data),  32'h0001);
    repeat (3) tick();
    chk("basic_last_data",    32'(a_out_data),  32'h0004);
    chk("basic_last_flag",    32'(a_out_last),  32'd1);
    chk("basic_last_index",   32'(a_out_index), 32'd3);
    tick();
    chk("basic_done_valid",   32'(a_out_valid), 32'd0);
    chk("basic_beats",        32'(a_beats - beats0), 32'd4);
    chk("basic_sb_empty",     32'(sb_a.size()), 32'd0);

    // Backpressure pattern
    beats0 = a_beats;
    cap_a(16'h0001, 1'b1);
    tick();
    for (int i = 0; i < 7; i++) begin
      a_out_ready = pattern[i][0];
      tick();
    end
    a_out_ready = 1'b1;
    chk("bp_done_valid", 32'(a_out_valid), 32'd0);
    chk("bp_beats",      32'(a_beats - beats0), 32'd4);
    chk("bp_sb_empty",   32'(sb_a.size()), 32'd0);

    // Double buffer: A then B one cycle apart
    beats0 = a_beats;
    cap_a(16'h0001, 1'b1);
    cap_a(16'h0005, 1'b1);
    chk("db_in_ready_full",  32'(a_in_ready), 32'd0);
    chk("db_first_data",     32'(a_out_data), 32'h0001);
    repeat (3) tick();
    chk("db_in_ready_a_last", 32'(a_in_ready), 32'd0);
    chk("db_a_last_flag",     32'(a_out_last), 32'd1);
    tick();
    chk("db_in_ready_freed", 32'(a_in_ready),  32'd1);
    chk("db_no_bubble",      32'(a_out_valid), 32'd1);
    chk("db_b_first_data",   32'(a_out_data),  32'h0005);
    repeat (4) tick();
    chk("db_done_valid",     32'(a_out_valid), 32'd0);
    chk("db_beats",          32'(a_beats - beats0), 32'd8);
    chk("db_sb_empty",       32'(sb_a.size()), 32'd0);

    // Overflow: third vector while both slots are full and the stream is stalled
    beats0 = a_beats;
    a_out_ready = 1'b0;
    cap_a(16'h0001, 1'b1);
    cap_a(16'h0005, 1'b1);
    chk("ovf_not_yet",      32'(a_overflow), 32'd0);
    cap_a(16'h0009, 1'b0);
    chk("ovf_set",          32'(a_overflow), 32'd1);
    chk("ovf_in_ready",     32'(a_in_ready), 32'd0);
    chk("ovf_head_held",    32'(a_out_data), 32'h0001);
    a_out_ready = 1'b1;
    wait_idle(1'b0, "ovf_drain_timeout", 40);
    chk("ovf_beats",        32'(a_beats - beats0), 32'd8);
    chk("ovf_sb_empty",     32'(sb_a.size()), 32'd0);
    chk("ovf_sticky",       32'(a_overflow), 32'd1);

    // soft_reset while a vector is pending
    a_out_ready = 1'b0;
    cap_a(16'h000D, 1'b0);
    tick();
    chk("sr_busy_before",   32'(a_busy), 32'd1);
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    chk("sr_overflow",      32'(a_overflow),  32'd0);
    chk("sr_busy",          32'(a_busy),      32'd0);
    chk("sr_valid",         32'(a_out_valid), 32'd0);
    chk("sr_in_ready",      32'(a_in_ready),  32'd1);
    beats0 = a_beats;
    a_out_ready = 1'b1;
    repeat (4) tick();
    chk("sr_no_emission",   32'(a_beats - beats0), 32'd0);
    chk("sr_still_idle",    32'(a_out_valid), 32'd0);

    // Async reset after the second beat of a vector
    beats0 = a_beats;
    cap_a(16'h0001, 1'b1);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    sb_a.delete();
    #1;
    chk("arst_valid_now",   32'(a_out_valid), 32'd0);
    chk("arst_busy_now",    32'(a_busy),      32'd0);
    chk("arst_data_now",    32'(a_out_data),  32'd0);
    chk("arst_beats_before", 32'(a_beats - beats0), 32'd2);
    #20;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("arst_quiet_valid", 32'(a_out_valid), 32'd0);
    chk("arst_quiet_beats", 32'(a_beats - beats0), 32'd2);
    cap_a(16'h0009, 1'b1);
    wait_idle(1'b0, "arst_new_timeout", 20);
    chk("arst_new_beats",   32'(a_beats - beats0), 32'd6);
    chk("arst_sb_empty",    32'(sb_a.size()), 32'd0);

    // One-word vectors
    beats0 = b_beats;
    cap_b(16'hBEEF, 1'b1);
    chk("b_no_valid_yet",   32'(b_out_valid), 32'd0);
    tick();
    chk("b_first_valid",    32'(b_out_valid), 32'd1);
    chk("b_first_data",     32'(b_out_data),  32'hBEEF);
    chk("b_first_last",     32'(b_out_last),  32'd1);
    chk("b_first_index",    32'(b_out_index), 32'd0);
    cap_b(16'hCAFE, 1'b1);
    chk("b_no_bubble",      32'(b_out_valid), 32'd1);
    chk("b_second_data",    32'(b_out_data),  32'hCAFE);
    tick();
    chk("b_done_valid",     32'(b_out_valid), 32'd0);
    chk("b_beats",          32'(b_beats - beats0), 32'd2);

    // Capture coinciding with the last beat while both slots are full
    beats0 = b_beats;
    cap_b(16'h1111, 1'b1);
    cap_b(16'h2222, 1'b1);
    chk("b_full_in_ready",  32'(b_in_ready), 32'd0);
    chk("b_full_head",      32'(b_out_data), 32'h1111);
    cap_b(16'h3333, 1'b1);
    chk("b_swap_overflow",  32'(b_overflow), 32'd0);
    chk("b_swap_data",      32'(b_out_data), 32'h2222);
    chk("b_swap_in_ready",  32'(b_in_ready), 32'd0);
    wait_idle(1'b1, "b_drain_timeout", 20);
    chk("b_swap_beats",     32'(b_beats - beats0), 32'd3);
    chk("b_sb_empty",       32'(sb_b.size()), 32'd0);
    chk("b_final_overflow", 32'(b_overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
